// File: rtl/jtag_scan_engine.sv
// jtag_scan_engine
//   Command-driven JTAG pin sequencer. It accepts one scan command at a time
//   over a valid/ready port and plays it out on TCK/TMS/TDI/TRSTn with a TCK
//   half-period of TICK_DELAY+1 clocks. During shift bits it captures TDO into
//   a response word, which it returns over a valid/ready port.
//
// Ports
//   clock, reset          : sole clock, asynchronous active-high reset
//   enable                : freezes all TCK progress while low (RUN only)
//   init_done             : sticky; no command is accepted before it is seen high
//   cmd_valid/cmd_ready   : command handshake
//   cmd_op                : 0=TAP reset, 1=IR scan, 2=DR scan, 3=idle clocks
//   cmd_len               : shift bits (scans) or TCK periods (idle)
//   cmd_data              : TDI bits, LSB shifted first
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data              : captured TDO bits, LSB = first shifted
//   rsp_error             : scan rejected for a bad length
//   rsp_undriven          : some captured bit had jtag_TDO_driven = 0
//   jtag_TCK/TMS/TDI/TRSTn: registered JTAG pins
//   jtag_TDO_data/driven  : DUT TDO and its drive enable
//   busy                  : a command is in progress
module jtag_scan_engine #(
    parameter int MAX_BITS   = 64,
    parameter int TICK_DELAY = 50,
    parameter int RESET_BITS = 5,
    parameter int LEN_W      = $clog2(MAX_BITS + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                init_done,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [MAX_BITS-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [MAX_BITS-1:0] rsp_data,
    output logic                rsp_error,
    output logic                rsp_undriven,
    output logic                jtag_TCK,
    output logic                jtag_TMS,
    output logic                jtag_TDI,
    output logic                jtag_TRSTn,
    input  logic                jtag_TDO_data,
    input  logic                jtag_TDO_driven,
    output logic                busy
);

    localparam int HALF     = TICK_DELAY + 1;
    localparam int PERIOD   = 2 * HALF;
    localparam int HC_W     = $clog2(PERIOD);
    localparam int IDLE_MAX = (1 << LEN_W) - 1;
    localparam int SCAN_MAX = MAX_BITS + 6;
    localparam int MAX_A    = (SCAN_MAX > IDLE_MAX) ? SCAN_MAX : IDLE_MAX;
    localparam int MAX_N    = (MAX_A > RESET_BITS + 1) ? MAX_A : RESET_BITS + 1;
    localparam int BIT_W    = $clog2(MAX_N + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RESP} state_t;

    // Position of the first shift bit inside the TMS sequence.
    function automatic int shift_off(input logic [1:0] op);
        return (op == 2'd1) ? 4 : 3;
    endfunction

    function automatic logic is_scan(input logic [1:0] op);
        return (op == 2'd1) || (op == 2'd2);
    endfunction

    function automatic logic tms_bit(input logic [1:0] op, input int len, input int k);
        int off;
        off = shift_off(op);
        case (op)
            2'd0:    tms_bit = (k < RESET_BITS);
            2'd3:    tms_bit = 1'b0;
            default: begin
                if (k < off) tms_bit = (op == 2'd1) ? (k < 2) : (k == 0);
                else         tms_bit = (k == off + len - 1) || (k == off + len);
            end
        endcase
    endfunction

    function automatic logic tdi_bit(input logic [1:0] op, input int len,
                                     input logic [MAX_BITS-1:0] data, input int k);
        logic [MAX_BITS-1:0] shifted;
        int off;
        off = shift_off(op);
        shifted = data >> (k - off);
        return is_scan(op) && (k >= off) && (k < off + len) && shifted[0];
    endfunction

    function automatic logic trst_bit(input logic [1:0] op, input int k);
        return !((op == 2'd0) && (k < RESET_BITS));
    endfunction

    state_t              state_q, state_d;
    logic [HC_W-1:0]     half_q, half_d;
    logic [BIT_W-1:0]    bit_q, bit_d, nbits_q, nbits_d;
    logic [1:0]          op_q, op_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [MAX_BITS-1:0] data_q, data_d, rsp_data_q, rsp_data_d;
    logic                rsp_error_q, rsp_error_d, rsp_undriven_q, rsp_undriven_d;
    logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, trst_n_q, trst_n_d;
    logic                init_q, init_d, busy_q, busy_d;
    logic                bad_len, sample;
    int                  n_new, k_cur, off_cur;

    assign cmd_ready    = (state_q == ST_IDLE) && init_q;
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_data     = rsp_data_q;
    assign rsp_error    = rsp_error_q;
    assign rsp_undriven = rsp_undriven_q;
    assign jtag_TCK     = tck_q;
    assign jtag_TMS     = tms_q;
    assign jtag_TDI     = tdi_q;
    assign jtag_TRSTn   = trst_n_q;
    assign busy         = busy_q;

    always_comb begin
        // NOTE: every next-state value defaults to its hold value first, so no
        // path through the case arms below can leave one unassigned (latch).
        state_d        = state_q;
        half_d         = half_q;
        bit_d          = bit_q;
        nbits_d        = nbits_q;
        op_d           = op_q;
        len_d          = len_q;
        data_d         = data_q;
        rsp_data_d     = rsp_data_q;
        rsp_error_d    = rsp_error_q;
        rsp_undriven_d = rsp_undriven_q;
        tck_d          = tck_q;
        tms_d          = tms_q;
        tdi_d          = tdi_q;
        trst_n_d       = trst_n_q;
        init_d         = init_q | init_done;
        busy_d         = (state_q != ST_IDLE) && !((state_q == ST_RESP) && rsp_ready);
        bad_len        = is_scan(cmd_op) && ((cmd_len == '0) || (int'(cmd_len) > MAX_BITS));
        sample         = jtag_TDO_driven & jtag_TDO_data;
        k_cur          = int'(bit_q);
        off_cur        = shift_off(op_q);
        case (cmd_op)
            2'd0:    n_new = RESET_BITS + 1;
            2'd1:    n_new = int'(cmd_len) + 6;
            2'd2:    n_new = int'(cmd_len) + 5;
            default: n_new = int'(cmd_len);
        endcase
        if (bad_len) n_new = 0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d        = ST_RUN;
                    op_d           = cmd_op;
                    len_d          = cmd_len;
                    data_d         = cmd_data;
                    nbits_d        = BIT_W'(n_new);
                    half_d         = '0;
                    bit_d          = '0;
                    rsp_data_d     = '0;
                    rsp_error_d    = bad_len;
                    rsp_undriven_d = 1'b0;
                    // Zero-bit commands leave the pins untouched.
                    if (n_new != 0) begin
                        tck_d    = 1'b0;
                        tms_d    = tms_bit(cmd_op, int'(cmd_len), 0);
                        tdi_d    = tdi_bit(cmd_op, int'(cmd_len), cmd_data, 0);
                        trst_n_d = trst_bit(cmd_op, 0);
                    end
                end
            end
            ST_RUN: begin
                // A zero-bit command spends exactly one cycle here, so its
                // response appears one edge after acceptance.
                if (nbits_q == '0) begin
                    state_d = ST_RESP;
                end else if (enable) begin
                    if (half_q == HC_W'(HALF - 1)) begin
                        tck_d  = 1'b1;
                        half_d = half_q + 1'b1;
                        if (is_scan(op_q) && (k_cur >= off_cur) && (k_cur < off_cur + int'(len_q))) begin
                            rsp_data_d = rsp_data_q
                                       | ({{(MAX_BITS-1){1'b0}}, sample} << (k_cur - off_cur));
                            if (!jtag_TDO_driven) rsp_undriven_d = 1'b1;
                        end
                    end else if (half_q == HC_W'(PERIOD - 1)) begin
                        tck_d  = 1'b0;
                        half_d = '0;
                        if (bit_q == nbits_q - 1'b1) begin
                            state_d  = ST_RESP;
                            tms_d    = 1'b0;
                            tdi_d    = 1'b0;
                            trst_n_d = 1'b1;
                        end else begin
                            bit_d    = bit_q + 1'b1;
                            tms_d    = tms_bit(op_q, int'(len_q), k_cur + 1);
                            tdi_d    = tdi_bit(op_q, int'(len_q), data_q, k_cur + 1);
                            trst_n_d = trst_bit(op_q, k_cur + 1);
                        end
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            half_q         <= '0;
            bit_q          <= '0;
            nbits_q        <= '0;
            op_q           <= 2'd0;
            len_q          <= '0;
            data_q         <= '0;
            rsp_data_q     <= '0;
            rsp_error_q    <= 1'b0;
            rsp_undriven_q <= 1'b0;
            tck_q          <= 1'b0;
            tms_q          <= 1'b1;
            tdi_q          <= 1'b0;
            trst_n_q       <= 1'b1;
            init_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            half_q         <= half_d;
            bit_q          <= bit_d;
            nbits_q        <= nbits_d;
            op_q           <= op_d;
            len_q          <= len_d;
            data_q         <= data_d;
            rsp_data_q     <= rsp_data_d;
            rsp_error_q    <= rsp_error_d;
            rsp_undriven_q <= rsp_undriven_d;
            tck_q          <= tck_d;
            tms_q          <= tms_d;
            tdi_q          <= tdi_d;
            trst_n_q       <= trst_n_d;
            init_q         <= init_d;
            busy_q         <= busy_d;
        end
    end

endmodule

// File: tb/tb_jtag_scan_engine.sv
// Directed bench for jtag_scan_engine with TICK_DELAY=1 (TCK period 4 clocks).
module tb_jtag_scan_engine;

    localparam int H = 2;
    localparam int P = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        init_done = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [6:0]  cmd_len = '0;
    logic [63:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic        rsp_error, rsp_undriven;
    logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic        jtag_TDO_data, jtag_TDO_driven;
    logic        busy;

    // DUT-side TDO model: either echo TDI delayed one TCK period, or a constant.
    logic tdo_reg = 1'b0;
    logic tdo_echo = 1'b1;
    logic tdo_const = 1'b0;
    logic tdo_drv = 1'b1;
    always @(posedge jtag_TCK) tdo_reg <= jtag_TDI;
    assign jtag_TDO_data   = tdo_echo ? tdo_reg : tdo_const;
    assign jtag_TDO_driven = tdo_drv;

    int   checks = 0;
    int   errors = 0;
    logic tck_seen;

    always #5 clock = ~clock;

    jtag_scan_engine #(.MAX_BITS(64), .TICK_DELAY(1), .RESET_BITS(5)) dut (
        .clock(clock), .reset(reset), .enable(enable), .init_done(init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .rsp_undriven(rsp_undriven), .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS),
        .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn), .jtag_TDO_data(jtag_TDO_data),
        .jtag_TDO_driven(jtag_TDO_driven), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Returns just after the acceptance edge E0.
    task automatic send(input logic [1:0] op, input int len, input logic [63:0] data);
        int n;
        n = 0;
        cmd_op = op; cmd_len = 7'(len); cmd_data = data; cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 200) begin step(); n++; end
        check("send_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        check("busy_at_e0", busy, 0);
    endtask

    task automatic wait_rsp(input string tag, input int already, input int exp_lat);
        int n;
        n = already;
        tck_seen = 1'b0;
        while (rsp_valid !== 1'b1 && n < 2000) begin
            step(); n++;
            if (jtag_TCK === 1'b1) tck_seen = 1'b1;
        end
        check({tag, "_latency"}, n, exp_lat);
    endtask

    // Walks every bit from E0, checking pins at bit start and the high phase,
    // then checks the response edge at E0 + n*P.
    task automatic run_bits(input string tag, input int n, input logic [127:0] tms_e,
                            input logic [127:0] tdi_e, input logic [127:0] trst_e);
        for (int k = 0; k < n; k++) begin
            check({tag, "_tms"}, jtag_TMS, tms_e[k]);
            check({tag, "_tdi"}, jtag_TDI, tdi_e[k]);
            check({tag, "_trstn"}, jtag_TRSTn, trst_e[k]);
            check({tag, "_tck_lo"}, jtag_TCK, 0);
            check({tag, "_rsp_early"}, rsp_valid, 0);
            repeat (H) step();
            check({tag, "_tck_hi"}, jtag_TCK, 1);
            check({tag, "_busy"}, busy, 1);
            check({tag, "_cmd_ready_run"}, cmd_ready, 0);
            repeat (H) step();
        end
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_end_tck"}, jtag_TCK, 0);
        check({tag, "_end_tms"}, jtag_TMS, 0);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("consume_rsp_valid", rsp_valid, 0);
        check("consume_busy", busy, 0);
        check("consume_cmd_ready", cmd_ready, 1);
    endtask

    task automatic pulse_init();
        init_done = 1'b1;
        step();
        init_done = 1'b0;
        check("init_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] v_tms, v_tdi;

        // Reset values.
        repeat (2) step();
        reset = 1'b0;
        check("rst_tck", jtag_TCK, 0);
        check("rst_tms", jtag_TMS, 1);
        check("rst_tdi", jtag_TDI, 0);
        check("rst_trstn", jtag_TRSTn, 1);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_rsp_undriven", rsp_undriven, 0);
        check("rst_busy", busy, 0);

        // No acceptance before init_done.
        cmd_valid = 1'b1;
        repeat (3) step();
        check("preinit_busy", busy, 0);
        check("preinit_ready", cmd_ready, 0);
        check("preinit_tck", jtag_TCK, 0);
        cmd_valid = 1'b0;
        pulse_init();
        repeat (2) step();
        check("init_sticky", cmd_ready, 1);

        // TAP reset: 5 x TMS=1 with TRSTn low, then one TMS=0 period.
        send(2'd0, 0, 64'h0);
        run_bits("op0", 6, 128'h1F, 128'h0, 128'h20);
        check("op0_rsp_data", rsp_data, 0);
        check("op0_rsp_error", rsp_error, 0);
        consume();

        // DR scan len 8, TDO echoes TDI one bit late.
        send(2'd2, 8, 64'hA5);
        run_bits("dr8", 13, 128'hC01, 128'h528, '1);
        check("dr8_rsp_data", rsp_data, 64'h4A);
        check("dr8_undriven", rsp_undriven, 0);
        check("dr8_error", rsp_error, 0);
        consume();

        // IR scan len 5 with TDO undriven.
        tdo_drv = 1'b0;
        send(2'd1, 5, 64'h11);
        run_bits("ir5", 11, 128'h303, 128'h110, '1);
        check("ir5_rsp_data", rsp_data, 0);
        check("ir5_undriven", rsp_undriven, 1);
        consume();
        tdo_drv = 1'b1;

        // Bad lengths.
        send(2'd2, 0, '1);
        wait_rsp("err0", 0, 1);
        check("err0_tck_toggle", tck_seen, 0);
        check("err0_error", rsp_error, 1);
        check("err0_data", rsp_data, 0);
        check("err0_tms", jtag_TMS, 0);
        consume();
        send(2'd2, 65, '1);
        wait_rsp("err65", 0, 1);
        check("err65_tck_toggle", tck_seen, 0);
        check("err65_error", rsp_error, 1);
        check("err65_data", rsp_data, 0);
        consume();

        // Full-width scan with TDO held high.
        tdo_echo = 1'b0;
        tdo_const = 1'b1;
        v_tms = '0; v_tms[0] = 1'b1; v_tms[66] = 1'b1; v_tms[67] = 1'b1;
        v_tdi = '0;
        for (int i = 3; i < 67; i++) v_tdi[i] = 1'b1;
        send(2'd2, 64, '1);
        run_bits("dr64", 69, v_tms, v_tdi, '1);
        check("dr64_rsp_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("dr64_error", rsp_error, 0);
        consume();
        tdo_echo = 1'b1;

        // Enable freeze in bit 4's high phase, then delayed consumption.
        send(2'd2, 4, 64'h6);
        repeat (19) step();
        check("frz_pre_tck", jtag_TCK, 1);
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check("frz_tck", jtag_TCK, 1);
            check("frz_tms", jtag_TMS, 0);
            check("frz_tdi", jtag_TDI, 1);
        end
        enable = 1'b1;
        wait_rsp("frz", 26, 43);
        check("frz_rsp_data", rsp_data, 64'hC);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_busy", busy, 1);
            check("hold_rsp_data", rsp_data, 64'hC);
        end
        consume();

        // Zero-length idle responds at once without error.
        send(2'd3, 0, 64'h0);
        wait_rsp("idle0", 0, 1);
        check("idle0_tck_toggle", tck_seen, 0);
        check("idle0_error", rsp_error, 0);
        consume();

        // Asynchronous reset during bit 3 of a DR scan.
        send(2'd2, 8, 64'hFF);
        repeat (14) step();
        check("abort_pre_tck", jtag_TCK, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_tck", jtag_TCK, 0);
        check("abort_tms", jtag_TMS, 1);
        check("abort_tdi", jtag_TDI, 0);
        check("abort_trstn", jtag_TRSTn, 1);
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        step();
        reset = 1'b0;
        repeat (3) step();
        check("abort_no_rsp", rsp_valid, 0);
        check("abort_init_cleared", cmd_ready, 0);
        pulse_init();
        send(2'd3, 3, 64'h0);
        run_bits("idle3", 3, 128'h0, 128'h0, '1);
        check("idle3_rsp_data", rsp_data, 0);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_scan_engine.md
# jtag_scan_engine

Parametrised successor to the DPI-ticked JTAG driver. Instead of consuming a host tick per edge, it accepts whole scan commands (TAP reset, IR scan, DR scan, idle clocks) over a valid/ready port and generates TCK/TMS/TDI/TRSTn with a programmable TCK period. It captures TDO into a response word, and sits between a test harness (or debug-transport model) and the DUT's JTAG pins. Shift length, TCK half-period and reset length are parameters.

## Interface
- `MAX_BITS`, 64: maximum shift length; width of `cmd_data` and `rsp_data`.
- `TICK_DELAY`, 50: TCK half-period is `TICK_DELAY+1` clocks.
- `RESET_BITS`, 5: number of TMS=1 TCK periods in a TAP reset command.
- `LEN_W`, `$clog2(MAX_BITS+1)`: width of `cmd_len`.

- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: when low, all TCK progress freezes.
- `init_done` in 1: sticky-captured; no command is accepted before it has been seen high.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_op` in 2: 0=TAP reset, 1=IR scan, 2=DR scan, 3=idle clocks.
- `cmd_len` in LEN_W: number of shift bits (scan ops) or TCK periods (op 3).
- `cmd_data` in MAX_BITS: TDI bits, LSB shifted first.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_data` out MAX_BITS: captured TDO bits, LSB = first shifted.
- `rsp_error` out 1: command rejected for a bad length.
- `rsp_undriven` out 1: at least one captured bit had `jtag_TDO_driven`=0.
- `jtag_TCK`, `jtag_TMS`, `jtag_TDI`, `jtag_TRSTn` out 1 each: JTAG pins, all registered.
- `jtag_TDO_data`, `jtag_TDO_driven` in 1 each: DUT TDO and its drive enable.
- `busy` out 1: a command is in progress.

## Operation
- States:
  - IDLE: `cmd_ready`=1 iff `init_done_sticky`.
  - RUN: the TCK bit sequencer.
  - RESP: `rsp_valid`=1.
- Only one command is outstanding at a time; `cmd_ready`=0 in RUN and RESP.
- The TAP is assumed in Run-Test/Idle between commands. Each command ends in Run-Test/Idle.
- TMS sequences (one entry per TCK period):
  - op0: `RESET_BITS` × 1, then 0. `jtag_TRSTn`=0 during the first `RESET_BITS` periods.
  - op1: 1,1,0,0, then len bits (0 except the last bit =1), then 1,0.
  - op2: 1,0,0, then len bits (0 except the last bit =1), then 1,0.
  - op3: len × 0.
- TDI carries `cmd_data[i]` during shift bit i and is 0 elsewhere.
- TDO capture:
  - Sampled only during shift bits, on the clock edge that raises TCK.
  - Captured value = `jtag_TDO_data` if driven, else 0; an undriven sample sets `rsp_undriven`.
  - `rsp_data[i]` = sample for bit i; bits ≥ len are 0. Ops 0 and 3 return `rsp_data`=0.
- Bad length: scan op with len=0 or len>`MAX_BITS`. The engine goes directly IDLE→RESP with `rsp_error`=1, `rsp_data`=0, and no pin activity.
- op3 with len=0 responds immediately with no error.
- `enable` low in RUN: the half-period counter, bit counter and pins hold. Progress resumes exactly where it stopped.
- `enable` does not affect IDLE acceptance or RESP.

## Timing
- Reset values:
  - `jtag_TCK`=0, `jtag_TMS`=1, `jtag_TDI`=0, `jtag_TRSTn`=1.
  - `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_error`=0, `rsp_undriven`=0, `busy`=0.
  - `init_done_sticky`=0.
- Reset asserted mid-command aborts immediately to these values. No response is produced.
- Acceptance edge E0 (`cmd_valid`&`cmd_ready`): bit 0's TMS/TDI load and TCK=0.
- Each bit lasts 2·(TICK_DELAY+1) clocks: TCK rises at E0+k·P+H and falls at E0+(k+1)·P, where H=TICK_DELAY+1 and P=2H.
- Bit counts N: op0 = RESET_BITS+1; op1 = len+6; op2 = len+5; op3 = len.
- `rsp_valid` rises at edge E0+N·P, with TCK=0 and TMS=0 at that edge. This assumes `enable` stays high.
- `rsp_valid` is held, with data stable, until `rsp_ready`. The engine returns to IDLE on that edge; `cmd_ready`=1 the following cycle.
- Error and zero-length-idle responses: `rsp_valid`=1 at E0+1.
- `busy`=1 from the edge after E0 until the response is consumed.

## Test plan
- Reset, then `init_done` pulsed for 1 cycle, TICK_DELAY=1, op0 → TMS high for 5 TCK periods with TRSTn=0, then 1 low period; `rsp_valid` at E0+24; `rsp_data`=0.
- op2, len=8, data=0xA5; DUT echoes TDI delayed by one bit and TDO driven → TDI 1,0,1,0,0,1,0,1 in shift; `rsp_data`=0x4A; `rsp_valid` at E0+52; `rsp_undriven`=0.
- op1, len=5, data=0x11, `jtag_TDO_driven`=0 → TMS 1,1,0,0,0,0,0,0,1,1,0; `rsp_data`=0; `rsp_undriven`=1.
- op2 with len=0, then len=MAX_BITS+1 → each gives `rsp_valid` at E0+1 with `rsp_error`=1 and no TCK toggles; a following len=`MAX_BITS` all-ones scan returns all ones.
- op2, len=4: drop `enable` for 7 cycles mid-high-phase, and hold `rsp_ready`=0 for 3 cycles → pins frozen for those 7 cycles; response 7 cycles late; `cmd_ready` low until the response is consumed.
- Assert `reset` asynchronously during bit 3 of a DR scan → pins return to reset values with no clock edge; no response; the next command runs normally once `init_done` is seen again.
